// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the PC sequencer
// Purpose: FSM state encoding, instruction size and default reset PC.
// Ports: none (package).
package pc_seq_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    TRAP = 2'd3
  } state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/branch_counter.sv
// rtl/branch_counter.sv - retired and taken-branch event counters
// Purpose: counts retiring instructions and the subset that took a branch target.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   retire_i         one instruction retires this cycle
//   taken_i          the retiring instruction took its target (qualified by retire_i)
//   retired_count_o  total retires, wraps at 2^32
//   taken_count_o    total taken retires, wraps at 2^32
module branch_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire_i,
  input  logic        taken_i,
  output logic [31:0] retired_count_o,
  output logic [31:0] taken_count_o
);

  logic [31:0] retired_q, retired_d;
  logic [31:0] taken_q, taken_d;

  always_comb begin
    retired_d = retired_q;
    taken_d   = taken_q;
    if (retire_i) begin
      retired_d = retired_q + 32'd1;
      if (taken_i) begin
        taken_d = taken_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign retired_count_o = retired_q;
  assign taken_count_o   = taken_q;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, instruction fetch FSM and decode holding register
// Purpose: owns the PC, fetches one instruction at a time over a req/gnt/rvalid port,
//   holds it for decode and applies the branch decision when it retires.
// Optional feature: define BRANCH_COUNT_EN to add retired_count/taken_count outputs.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   pc_src, target           branch decision and target, used on retire only
//   advance                  held instruction retires this cycle
//   imem_req/addr/gnt        fetch request, address (= pc), acceptance
//   imem_rvalid/rdata        fetch response
//   instr, instr_valid, pc   held instruction, its validity, its address
//   pc_plus4                 pc + 4 (combinational, wraps)
//   misalign                 sticky misaligned-taken-target flag
//   retired_count/taken_count  event counters (BRANCH_COUNT_EN only)
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              SIZE     = 32,
  parameter logic [SIZE-1:0] RESET_PC = SIZE'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_src,
  input  logic [SIZE-1:0] target,
  input  logic            advance,
  output logic            imem_req,
  output logic [SIZE-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [SIZE-1:0] pc,
  output logic [SIZE-1:0] pc_plus4,
  output logic            misalign
`ifdef BRANCH_COUNT_EN
  ,
  output logic [31:0]     retired_count,
  output logic [31:0]     taken_count
`endif
);

  state_t          state_q;
  logic [SIZE-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            misalign_q;
  logic            retire;

  assign pc_plus4 = pc_q + SIZE'(INSTR_BYTES);
  assign retire   = (state_q == HOLD) && advance;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        REQ: begin
          // rvalid without gnt belongs to no request of ours and is dropped
          if (imem_gnt) begin
            if (imem_rvalid) begin
              instr_q <= imem_rdata;
              state_q <= HOLD;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (advance) begin
            if (!pc_src) begin
              pc_q    <= pc_plus4;
              state_q <= REQ;
            end else if (target[1:0] == 2'b00) begin
              pc_q    <= target;
              state_q <= REQ;
            end else begin
              // pc keeps the faulting instruction's address for diagnosis
              misalign_q <= 1'b1;
              state_q    <= TRAP;
            end
          end
        end
        TRAP: state_q <= TRAP;
        default: state_q <= REQ;
      endcase
    end
  end

  // Request is suppressed while reset is asserted so an abandoned fetch is never re-issued.
  assign imem_req    = (state_q == REQ) && rst_n;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == HOLD);
  assign pc          = pc_q;
  assign misalign    = misalign_q;

`ifdef BRANCH_COUNT_EN
  branch_counter u_branch_counter (
    .clk             (clk),
    .rst_n           (rst_n),
    .retire_i        (retire),
    .taken_i         (pc_src),
    .retired_count_o (retired_count),
    .taken_count_o   (taken_count)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule
